fanout_fork_ctrl: RTL and testbench
===================================

// Module: fanout_fork_ctrl
// PURPOSE
//  Broadcast controller for one driver net fanning out to NUM_LOADS sinks across the hierarchy.
//  Accepts one word from the driver and delivers it to every enabled load with a per-load
//  valid/ready handshake. Target loads are served from a one-cycle buffer stage, which models an
//  inserted repeater. Non-target loads are served directly from the holding register.
//  Sits between a single producer and its distributed consumers; masks are set by the configuration layer.
// PARAMETERS
//  NUM_LOADS  6   number of load ports (1..32)
//  DATA_W     8   payload width
//  CNT_W      16  width of completed-transfer counter
// PORTS
//  clk              in   1            clock; all flops on rising edge
//  rst_n            in   1            asynchronous active-low reset
//  cfg_enable_mask  in   NUM_LOADS    load participates in broadcast
//  cfg_target_mask  in   NUM_LOADS    load is fed via buffer stage (+1 cycle)
//  in_valid         in   1            driver word valid
//  in_data          in   DATA_W       driver word
//  in_ready         out  1            controller can accept a word
//  load_valid       out  NUM_LOADS    per-load offer
//  load_ready       in   NUM_LOADS    per-load accept
//  load_data        out  NUM_LOADS*DATA_W  per-load payload (slice i = load i)
//  busy             out  1            transfer in flight (state != IDLE)
//  xfer_cnt         out  CNT_W        completed broadcasts, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; hold_q, buf_q, pending, en_q, tgt_q, xfer_cnt=0. Outputs: in_ready=1,
//   load_valid=0, load_data=0, busy=0. Reset asserted mid-transfer abandons the word silently.
//  Handshake: a transfer occurs on a load or the input when valid&&ready at the clock edge.
//   load_valid[i], once high, stays high with stable data until load_ready[i].
//  in_ready = (state==IDLE). load_valid/data are combinational from state plus registers only,
//   never from load_ready.
//  Capture (IDLE, in_valid): hold_q<=in_data; en_q<=cfg_enable_mask; tgt_q<=cfg_target_mask&cfg_enable_mask;
//   pending<=cfg_enable_mask. If cfg_enable_mask==0, the word is dropped, xfer_cnt+1, and state stays IDLE.
//   Otherwise state goes to FILL. Config masks are sampled only at capture; later changes do not affect the current word.
//  FILL (1 cycle): buf_q<=hold_q. Direct loads (pending & ~tgt_q) have valid=1 with data=hold_q.
//   Target loads have valid=0.
//  Leaving FILL: when pending is all-zero after this cycle's accepts, go to IDLE and add 1 to xfer_cnt.
//   This includes the case tgt_q==0 with all direct loads ready in FILL. Otherwise go to SERVE.
//  SERVE: every pending load has valid=1. Data is buf_q for target loads and hold_q for direct loads.
//   An accepted load clears its pending bit. When the last pending bit clears, go to IDLE and add 1 to
//   xfer_cnt on that same edge.
//  Latency: direct load sees valid 1 cycle after capture; target load sees valid 2 cycles after capture.
//   Peak throughput is 1 word per 2 cycles (capture + FILL).
//  Non-pending and disabled loads drive valid=0 and data=0.
//  load_ready on a non-pending load is ignored.
//  A load holding ready=0 stalls the controller indefinitely. No timeout.
//  xfer_cnt wraps from 2^CNT_W-1 to 0.
//  in_valid while busy has no effect. The driver must hold its word, since in_ready=0.
// STRUCTURE
//  Package fanout_pkg: state enum {IDLE, FILL, SERVE} (2-bit) and a MAX_LOADS=32 constant.
//  Sub-module fanout_load_slot, one instance per load. Inputs: state, pending bit, tgt bit, hold_q,
//   buf_q, load_ready. Outputs: load_valid, load_data, clear strobe.
//  The top holds the FSM, hold_q, buf_q, masks, pending vector and counter.
// TESTING
//  1) en=6'h3F, tgt=6'h26 (loads 1,2,5), all ready=1, in_data=8'hA5.
//     -> loads 0,3,4 accept in FILL, loads 1,2,5 accept in SERVE, all with 8'hA5;
//     xfer_cnt=1; in_ready returns 1 three cycles after capture.
//  2) en=6'h3F, tgt=0, all ready=1 -> complete in FILL, IDLE after 2 cycles, xfer_cnt=1.
//  3) en=6'h3F, tgt=6'h26, load3 ready held 0 for 5 cycles.
//     -> load_valid[3] high with stable data throughout; busy=1; completion on the edge load3 accepts.
//  4) en=0, in_valid with 8'h11 -> in_ready stays 1, no load_valid, xfer_cnt+1.
//  5) Change cfg masks during SERVE -> the in-flight word keeps its captured masks;
//     the next word uses the new masks.
//  6) Assert rst_n=0 during SERVE -> all outputs at reset values immediately (async);
//     after release in_ready=1 and xfer_cnt=0. Separately, preload xfer_cnt=16'hFFFF -> next completion gives 0.

Source files
------------

// File: rtl/fanout_pkg.sv
// Shared types and limits for the fan-out broadcast controller.
package fanout_pkg;

   localparam int unsigned MAX_LOADS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      SERVE = 2'd2
   } state_t;

endpackage : fanout_pkg

// File: rtl/fanout_load_slot.sv
// Per-load offer logic: selects direct or repeater-stage data and flags an accept.
module fanout_load_slot
   import fanout_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  state_t            i_state,
   input  logic              i_pending,
   input  logic              i_tgt,
   input  logic [DATA_W-1:0] i_hold,
   input  logic [DATA_W-1:0] i_buf,
   input  logic              i_load_ready,
   output logic              o_valid_c,
   output logic [DATA_W-1:0] o_data_c,
   output logic              o_clear_c
);

   logic w_offer;
   logic w_use_buf;

   // Target loads wait for the repeater stage, so they only offer in SERVE.
   always_comb begin
      w_offer   = 1'b0;
      w_use_buf = 1'b0;
      o_valid_c = 1'b0;
      o_data_c  = '0;
      o_clear_c = 1'b0;

      w_offer   = i_pending &&
                  (((i_state == FILL) && !i_tgt) || (i_state == SERVE));
      w_use_buf = (i_state == SERVE) && i_tgt;

      o_valid_c = w_offer;
      if (w_offer) begin
         o_data_c = w_use_buf ? i_buf : i_hold;
      end
      o_clear_c = w_offer && i_load_ready;
   end

endmodule : fanout_load_slot

// File: rtl/fanout_fork_ctrl.sv
// Broadcasts one driver word to every enabled load, with target loads fed
// through a one-cycle buffer stage standing in for an inserted repeater.
module fanout_fork_ctrl
   import fanout_pkg::*;
#(
   parameter int unsigned NUM_LOADS = 6,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_LOADS-1:0]        cfg_enable_mask,
   input  logic [NUM_LOADS-1:0]        cfg_target_mask,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_data,
   output logic                        in_ready,
   output logic [NUM_LOADS-1:0]        load_valid,
   input  logic [NUM_LOADS-1:0]        load_ready,
   output logic [NUM_LOADS*DATA_W-1:0] load_data,
   output logic                        busy,
   output logic [CNT_W-1:0]            xfer_cnt
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_W-1:0]      r_hold;
   logic [DATA_W-1:0]      r_buf;
   logic [NUM_LOADS-1:0]   r_en;
   logic [NUM_LOADS-1:0]   r_tgt;
   logic [NUM_LOADS-1:0]   r_pending;
   logic [CNT_W-1:0]       r_xfer_cnt;

   logic [NUM_LOADS-1:0]   w_slot_pending;
   logic [NUM_LOADS-1:0]   w_clear;
   logic [NUM_LOADS-1:0]   w_pending_nxt;
   logic                   w_capture;
   logic                   w_drop;
   logic                   w_in_flight;
   logic                   w_done;

   assign w_slot_pending = r_pending & r_en;
   assign w_pending_nxt  = r_pending & ~w_clear;
   assign w_capture      = (r_state == IDLE) && in_valid;
   assign w_drop         = w_capture && (cfg_enable_mask == '0);
   assign w_in_flight    = (r_state == FILL) || (r_state == SERVE);
   // A broadcast completes either as an empty-mask drop or when the last pending load accepts.
   assign w_done         = w_drop || (w_in_flight && (w_pending_nxt == '0));

   for (genvar gi = 0; gi < NUM_LOADS; gi++) begin : g_slot
      fanout_load_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .i_state      (r_state),
         .i_pending    (w_slot_pending[gi]),
         .i_tgt        (r_tgt[gi]),
         .i_hold       (r_hold),
         .i_buf        (r_buf),
         .i_load_ready (load_ready[gi]),
         .o_valid_c    (load_valid[gi]),
         .o_data_c     (load_data[gi*DATA_W +: DATA_W]),
         .o_clear_c    (w_clear[gi])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_capture && !w_drop) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            w_state_nxt = (w_pending_nxt == '0) ? IDLE : SERVE;
         end
         SERVE: begin
            if (w_pending_nxt == '0) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Controller-level outputs.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      in_ready = (r_state == IDLE);
      busy     = (r_state != IDLE);
   end

   // Word, mask, pending and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold     <= '0;
         r_buf      <= '0;
         r_en       <= '0;
         r_tgt      <= '0;
         r_pending  <= '0;
         r_xfer_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_hold    <= in_data;
            r_en      <= cfg_enable_mask;
            r_tgt     <= cfg_target_mask & cfg_enable_mask;
            r_pending <= cfg_enable_mask;
         end else if (w_in_flight) begin
            r_pending <= w_pending_nxt;
         end
         if (r_state == FILL) begin
            r_buf <= r_hold;
         end
         if (w_done) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
         end
      end
   end

   assign xfer_cnt = r_xfer_cnt;

endmodule : fanout_fork_ctrl

// File: tb/tb_fanout_fork_ctrl.sv
// Directed self-checking bench for fanout_fork_ctrl.
module tb_fanout_fork_ctrl;

   logic        clk;
   logic        rst_n;
   logic [5:0]  cfg_en;
   logic [5:0]  cfg_tgt;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [5:0]  load_valid;
   logic [5:0]  load_ready;
   logic [47:0] load_data;
   logic        busy;
   logic [15:0] xfer_cnt;

   logic [1:0]  s_en;
   logic [1:0]  s_tgt;
   logic        s_in_valid;
   logic [7:0]  s_in_data;
   logic        s_in_ready;
   logic [1:0]  s_load_valid;
   logic [1:0]  s_load_ready;
   logic [15:0] s_load_data;
   logic        s_busy;
   logic [2:0]  s_xfer_cnt;

   int checks = 0;
   int errors = 0;

   fanout_fork_ctrl #(.NUM_LOADS(6), .DATA_W(8), .CNT_W(16)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_enable_mask (cfg_en),
      .cfg_target_mask (cfg_tgt),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_data       (load_data),
      .busy            (busy),
      .xfer_cnt        (xfer_cnt)
   );

   fanout_fork_ctrl #(.NUM_LOADS(2), .DATA_W(8), .CNT_W(3)) u_small (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_enable_mask (s_en),
      .cfg_target_mask (s_tgt),
      .in_valid        (s_in_valid),
      .in_data         (s_in_data),
      .in_ready        (s_in_ready),
      .load_valid      (s_load_valid),
      .load_ready      (s_load_ready),
      .load_data       (s_load_data),
      .busy            (s_busy),
      .xfer_cnt        (s_xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [47:0] exp_data(input logic [5:0] m, input logic [7:0] v);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         if (m[i]) r[i*8 +: 8] = v;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 6'h00 ||
          load_data !== 48'h0 || xfer_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset: rdy=%b busy=%b vld=%h data=%h cnt=%h, want 1 0 00 0 0",
                  in_ready, busy, load_valid, load_data, xfer_cnt);
      end
   endtask

   task automatic test_mixed_targets();
      cfg_en = 6'h3F; cfg_tgt = 6'h26; load_ready = 6'h3F;
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      checks++;
      if (load_valid !== 6'h19 || load_data !== exp_data(6'h19, 8'hA5) ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mixed_fill: vld=%h data=%h rdy=%b, want 19 %h 0",
                  load_valid, load_data, in_ready, exp_data(6'h19, 8'hA5));
      end
      tick();
      checks++;
      if (load_valid !== 6'h26 || load_data !== exp_data(6'h26, 8'hA5) || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mixed_serve: vld=%h data=%h rdy=%b, want 26 %h 0",
                  load_valid, load_data, in_ready, exp_data(6'h26, 8'hA5));
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 6'h00 || xfer_cnt !== 16'd1) begin
         errors++;
         $display("FAIL mixed_done: rdy=%b busy=%b vld=%h cnt=%0d, want 1 0 00 1",
                  in_ready, busy, load_valid, xfer_cnt);
      end
   endtask

   task automatic test_all_direct();
      cfg_en = 6'h3F; cfg_tgt = 6'h00; load_ready = 6'h3F;
      in_valid = 1'b1; in_data = 8'h96;
      tick();
      in_valid = 1'b0;
      checks++;
      if (load_valid !== 6'h3F || load_data !== exp_data(6'h3F, 8'h96)) begin
         errors++;
         $display("FAIL direct_fill: vld=%h data=%h, want 3f %h",
                  load_valid, load_data, exp_data(6'h3F, 8'h96));
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || xfer_cnt !== 16'd2) begin
         errors++;
         $display("FAIL direct_done: rdy=%b busy=%b cnt=%0d, want 1 0 2", in_ready, busy, xfer_cnt);
      end
   endtask

   task automatic test_stall();
      cfg_en = 6'h3F; cfg_tgt = 6'h26; load_ready = 6'h37;
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      checks++;
      if (load_valid !== 6'h19) begin
         errors++;
         $display("FAIL stall_fill: vld=%h, want 19", load_valid);
      end
      tick();
      checks++;
      if (load_valid !== 6'h2E || load_data !== exp_data(6'h2E, 8'h3C)) begin
         errors++;
         $display("FAIL stall_serve: vld=%h data=%h, want 2e %h",
                  load_valid, load_data, exp_data(6'h2E, 8'h3C));
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (load_valid !== 6'h08 || load_data[31:24] !== 8'h3C || busy !== 1'b1 ||
             xfer_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_hold%0d: vld=%h d3=%h busy=%b cnt=%0d, want 08 3c 1 2",
                     c, load_valid, load_data[31:24], busy, xfer_cnt);
         end
      end
      load_ready = 6'h3F;
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 6'h00 || xfer_cnt !== 16'd3) begin
         errors++;
         $display("FAIL stall_done: rdy=%b busy=%b vld=%h cnt=%0d, want 1 0 00 3",
                  in_ready, busy, load_valid, xfer_cnt);
      end
   endtask

   task automatic test_empty_mask();
      cfg_en = 6'h00; cfg_tgt = 6'h00; load_ready = 6'h3F;
      in_valid = 1'b1; in_data = 8'h11;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL empty_pre: rdy=%b, want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 6'h00 || xfer_cnt !== 16'd4) begin
         errors++;
         $display("FAIL empty_drop: rdy=%b busy=%b vld=%h cnt=%0d, want 1 0 00 4",
                  in_ready, busy, load_valid, xfer_cnt);
      end
   endtask

   task automatic test_cfg_change();
      cfg_en = 6'h3F; cfg_tgt = 6'h26; load_ready = 6'h3D;
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      tick();
      cfg_en = 6'h0F; cfg_tgt = 6'h01;
      tick();
      checks++;
      if (load_valid !== 6'h02 || load_data !== exp_data(6'h02, 8'h5A) || busy !== 1'b1) begin
         errors++;
         $display("FAIL cfg_inflight: vld=%h data=%h busy=%b, want 02 %h 1",
                  load_valid, load_data, busy, exp_data(6'h02, 8'h5A));
      end
      load_ready = 6'h3F;
      tick();
      checks++;
      if (in_ready !== 1'b1 || xfer_cnt !== 16'd5) begin
         errors++;
         $display("FAIL cfg_done: rdy=%b cnt=%0d, want 1 5", in_ready, xfer_cnt);
      end
      in_valid = 1'b1; in_data = 8'hC3;
      tick();
      in_valid = 1'b0;
      checks++;
      if (load_valid !== 6'h0E || load_data !== exp_data(6'h0E, 8'hC3)) begin
         errors++;
         $display("FAIL cfg_next_fill: vld=%h data=%h, want 0e %h",
                  load_valid, load_data, exp_data(6'h0E, 8'hC3));
      end
      tick();
      checks++;
      if (load_valid !== 6'h01 || load_data !== exp_data(6'h01, 8'hC3)) begin
         errors++;
         $display("FAIL cfg_next_serve: vld=%h data=%h, want 01 %h",
                  load_valid, load_data, exp_data(6'h01, 8'hC3));
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || xfer_cnt !== 16'd6) begin
         errors++;
         $display("FAIL cfg_next_done: rdy=%b cnt=%0d, want 1 6", in_ready, xfer_cnt);
      end
   endtask

   task automatic test_async_reset();
      cfg_en = 6'h3F; cfg_tgt = 6'h26; load_ready = 6'h00;
      in_valid = 1'b1; in_data = 8'h77;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (load_valid !== 6'h3F || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: vld=%h busy=%b, want 3f 1", load_valid, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || load_valid !== 6'h00 ||
          load_data !== 48'h0 || xfer_cnt !== 16'h0) begin
         errors++;
         $display("FAIL rst_async: rdy=%b busy=%b vld=%h data=%h cnt=%h, want 1 0 00 0 0",
                  in_ready, busy, load_valid, load_data, xfer_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load_ready = 6'h3F;
      tick();
      checks++;
      if (in_ready !== 1'b1 || xfer_cnt !== 16'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_release: rdy=%b busy=%b cnt=%0d, want 1 0 0", in_ready, busy, xfer_cnt);
      end
   endtask

   task automatic test_cnt_wrap();
      s_en = 2'b00; s_tgt = 2'b00; s_load_ready = 2'b11;
      s_in_valid = 1'b1; s_in_data = 8'h42;
      for (int k = 0; k < 7; k++) tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_xfer_cnt !== 3'd7 || s_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pre: cnt=%0d rdy=%b, want 7 1", s_xfer_cnt, s_in_ready);
      end
      s_en = 2'b11;
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_load_valid !== 2'b11 || s_load_data !== 16'h4242) begin
         errors++;
         $display("FAIL wrap_fill: vld=%b data=%h, want 11 4242", s_load_valid, s_load_data);
      end
      tick();
      checks++;
      if (s_xfer_cnt !== 3'd0 || s_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_done: cnt=%0d rdy=%b, want 0 1", s_xfer_cnt, s_in_ready);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_en = '0; cfg_tgt = '0; in_valid = 1'b0; in_data = '0; load_ready = '0;
      s_en = '0; s_tgt = '0; s_in_valid = 1'b0; s_in_data = '0; s_load_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_reset();
      test_mixed_targets();
      test_all_direct();
      test_stall();
      test_empty_mask();
      test_cfg_change();
      test_async_reset();
      test_cnt_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fanout_fork_ctrl
